// File: rtl/axilm_arb_if.sv
// Bundle of the two requester ports and the AXI-Lite master local bus seen by axilm_arb.
// The master modport is the arbiter's view; slave is the view of whatever surrounds it.
interface axilm_arb_if;
    logic        s0_valid;
    logic [3:0]  s0_wstb;
    logic [31:0] s0_addr;
    logic [31:0] s0_wdata;
    logic        s0_ack;
    logic [31:0] s0_rdata;
    logic [1:0]  s0_resp;

    logic        s1_valid;
    logic [3:0]  s1_wstb;
    logic [31:0] s1_addr;
    logic [31:0] s1_wdata;
    logic        s1_ack;
    logic [31:0] s1_rdata;
    logic [1:0]  s1_resp;

    logic        m_ena;
    logic [3:0]  m_wstb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_done;
    logic [31:0] m_rdata;
    logic [1:0]  m_bresp;
    logic [1:0]  m_rresp;

    logic        busy;

    modport master (
        input  s0_valid, s0_wstb, s0_addr, s0_wdata,
        input  s1_valid, s1_wstb, s1_addr, s1_wdata,
        input  m_done, m_rdata, m_bresp, m_rresp,
        output s0_ack, s0_rdata, s0_resp,
        output s1_ack, s1_rdata, s1_resp,
        output m_ena, m_wstb, m_addr, m_wdata,
        output busy
    );

    modport slave (
        output s0_valid, s0_wstb, s0_addr, s0_wdata,
        output s1_valid, s1_wstb, s1_addr, s1_wdata,
        output m_done, m_rdata, m_bresp, m_rresp,
        input  s0_ack, s0_rdata, s0_resp,
        input  s1_ack, s1_rdata, s1_resp,
        input  m_ena, m_wstb, m_addr, m_wdata,
        input  busy
    );
endinterface

// File: rtl/axilm_arb.sv
// Two-requester round-robin front end for an AXI-Lite master local bus: one access in flight,
// WAIT-state timeout answered with SLVERR, per-requester result registers.
module axilm_arb #(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    axilm_arb_if.master bus
);

    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Requester ports gathered into arrays so the grant can index them directly.
    logic [1:0]  req_valid;
    logic [3:0]  req_wstb  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];

    assign req_valid    = {bus.s1_valid, bus.s0_valid};
    assign req_wstb[0]  = bus.s0_wstb;
    assign req_wstb[1]  = bus.s1_wstb;
    assign req_addr[0]  = bus.s0_addr;
    assign req_addr[1]  = bus.s1_addr;
    assign req_wdata[0] = bus.s0_wdata;
    assign req_wdata[1] = bus.s1_wdata;

    logic        last_gnt_reg;
    logic        gnt_idx_reg;
    logic [3:0]  wstb_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [15:0] cnt_reg;

    logic        any_req;
    logic        win_idx;
    logic        timeout_hit;

    logic        grant;
    logic        capture;
    logic [31:0] cap_rdata;
    logic [1:0]  cap_resp;
    logic        m_ena_c;
    logic        resp_c;
    logic [1:0]  ack_vec;

    // Contention goes to the requester that did not win last time.
    always_comb begin
        any_req = |req_valid;
        win_idx = 1'b0;
        if (req_valid == 2'b11) begin
            win_idx = ~last_gnt_reg;
        end else if (req_valid[1]) begin
            win_idx = 1'b1;
        end
    end

    assign timeout_hit = (cnt_reg == TO_LAST);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        capture    = 1'b0;
        cap_rdata  = 32'd0;
        cap_resp   = 2'b00;
        m_ena_c    = 1'b0;
        resp_c     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                m_ena_c    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A completion arriving on the timeout cycle still delivers the master's result.
                if (bus.m_done) begin
                    capture    = 1'b1;
                    cap_rdata  = bus.m_rdata;
                    cap_resp   = (wstb_reg != 4'd0) ? bus.m_bresp : bus.m_rresp;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    capture    = 1'b1;
                    cap_rdata  = 32'd0;
                    cap_resp   = 2'b10;
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            last_gnt_reg <= 1'b1;
            gnt_idx_reg  <= 1'b0;
            wstb_reg     <= 4'd0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            cnt_reg      <= 16'd0;
        end else begin
            if (grant) begin
                last_gnt_reg <= win_idx;
                gnt_idx_reg  <= win_idx;
                wstb_reg     <= req_wstb[win_idx];
                addr_reg     <= req_addr[win_idx];
                wdata_reg    <= req_wdata[win_idx];
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= 16'd0;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    // Each requester keeps its last result until it is granted and completed again.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic [31:0] rdata_reg;
        logic [1:0]  resp_reg;

        always_ff @(posedge ACLK) begin
            if (!ARESETn) begin
                rdata_reg <= 32'd0;
                resp_reg  <= 2'b00;
            end else if (capture && (gnt_idx_reg == 1'(gi))) begin
                rdata_reg <= cap_rdata;
                resp_reg  <= cap_resp;
            end
        end
    end

    assign ack_vec = !resp_c      ? 2'b00 :
                     gnt_idx_reg  ? 2'b10 : 2'b01;

    assign bus.s0_ack   = ack_vec[0];
    assign bus.s1_ack   = ack_vec[1];
    assign bus.s0_rdata = g_req[0].rdata_reg;
    assign bus.s1_rdata = g_req[1].rdata_reg;
    assign bus.s0_resp  = g_req[0].resp_reg;
    assign bus.s1_resp  = g_req[1].resp_reg;

    assign bus.m_ena    = m_ena_c;
    assign bus.m_wstb   = wstb_reg;
    assign bus.m_addr   = addr_reg;
    assign bus.m_wdata  = wdata_reg;
    assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_axilm_arb.sv
// Self-checking bench for axilm_arb: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-age model of the arbiter.
module tb_axilm_arb;

    localparam int TO = 8;

    logic ACLK = 1'b0;
    logic ARESETn;

    axilm_arb_if bus();

    axilm_arb #(.TO_CYCLES(TO)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access is tracked by its age in cycles since the grant edge (age 1 = m_ena cycle,
    // ages 2..TO+1 are the waiting window); ack_age is the cycle the result is due.
    bit          mv = 1'b0;
    bit          mi;
    int          mage;
    int          mack;
    bit          mlast;
    bit          midx;
    logic [3:0]  mw;
    logic [31:0] ma;
    logic [31:0] md;
    logic [31:0] sr [2];
    logic [1:0]  sp [2];

    always @(negedge ACLK) begin
        logic       exp_ena;
        logic [1:0] exp_ack;
        logic [1:0] v;
        if (mv) begin
            exp_ena = mi && (mage == 1);
            exp_ack = 2'b00;
            if (mi && (mack == mage)) exp_ack[midx] = 1'b1;
            check("busy",     32'(bus.busy),   32'(mi));
            check("m_ena",    32'(bus.m_ena),  32'(exp_ena));
            check("s0_ack",   32'(bus.s0_ack), 32'(exp_ack[0]));
            check("s1_ack",   32'(bus.s1_ack), 32'(exp_ack[1]));
            check("m_wstb",   32'(bus.m_wstb), 32'(mw));
            check("m_addr",   bus.m_addr,      ma);
            check("m_wdata",  bus.m_wdata,     md);
            check("s0_rdata", bus.s0_rdata,    sr[0]);
            check("s0_resp",  32'(bus.s0_resp), 32'(sp[0]));
            check("s1_rdata", bus.s1_rdata,    sr[1]);
            check("s1_resp",  32'(bus.s1_resp), 32'(sp[1]));
            if (exp_ack != 2'b00)
                $display("txn req%0d %s addr=0x%08h rdata=0x%08h resp=%0d",
                         midx, (mw != 4'd0) ? "write" : "read ", ma, sr[midx], sp[midx]);
        end
        if (!ARESETn) begin
            mv = 1'b1; mi = 1'b0; mage = 0; mack = -1; mlast = 1'b1; midx = 1'b0;
            mw = 4'd0; ma = 32'd0; md = 32'd0;
            sr[0] = 32'd0; sr[1] = 32'd0; sp[0] = 2'b00; sp[1] = 2'b00;
        end else if (mv) begin
            if (!mi) begin
                v = {bus.s1_valid, bus.s0_valid};
                if (v != 2'b00) begin
                    midx  = (v == 2'b11) ? !mlast : v[1];
                    mlast = midx;
                    mw    = midx ? bus.s1_wstb  : bus.s0_wstb;
                    ma    = midx ? bus.s1_addr  : bus.s0_addr;
                    md    = midx ? bus.s1_wdata : bus.s0_wdata;
                    mi    = 1'b1;
                    mage  = 1;
                    mack  = -1;
                end
            end else if (mack == mage) begin
                mi   = 1'b0;
                mack = -1;
            end else begin
                if (mack < 0 && mage >= 2) begin
                    if (bus.m_done) begin
                        sr[midx] = bus.m_rdata;
                        sp[midx] = (mw != 4'd0) ? bus.m_bresp : bus.m_rresp;
                        mack     = mage + 1;
                    end else if (mage == TO + 1) begin
                        sr[midx] = 32'd0;
                        sp[midx] = 2'b10;
                        mack     = mage + 1;
                    end
                end
                mage++;
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_req(input int who, input logic v, input logic [3:0] s,
                           input logic [31:0] a, input logic [31:0] d);
        if (who == 0) begin
            bus.s0_valid = v; bus.s0_wstb = s; bus.s0_addr = a; bus.s0_wdata = d;
        end else begin
            bus.s1_valid = v; bus.s1_wstb = s; bus.s1_addr = a; bus.s1_wdata = d;
        end
    endtask

    task automatic do_reset(input int cycles);
        ARESETn = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        ARESETn = 1'b1;
    endtask

    // One access by requester `who`; the master answers `lat` cycles after m_ena (-1 = never).
    task automatic txn(input int who, input logic [3:0] wstb, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input logic [31:0] rd,
                       input logic [1:0] br, input logic [1:0] rr,
                       output int ena_n, output int ack_dt,
                       output logic [31:0] g_addr, output logic [31:0] g_wdata,
                       output logic [3:0] g_wstb, output logic [31:0] g_rdata,
                       output logic [1:0] g_resp);
        int ena_t;
        ena_t = -1; ena_n = 0; ack_dt = -1;
        g_addr = 32'd0; g_wdata = 32'd0; g_wstb = 4'd0; g_rdata = 32'd0; g_resp = 2'b00;
        set_req(who, 1'b1, wstb, addr, wdata);
        for (int c = 0; c < 40 && ack_dt < 0; c++) begin
            tick();
            bus.m_done = 1'b0;
            if (bus.m_ena) begin
                ena_n++;
                ena_t = c;
                g_addr = bus.m_addr; g_wdata = bus.m_wdata; g_wstb = bus.m_wstb;
            end
            if (lat >= 0 && ena_t >= 0 && c == ena_t + lat) begin
                bus.m_done = 1'b1; bus.m_rdata = rd; bus.m_bresp = br; bus.m_rresp = rr;
            end
            if ((who == 0) ? bus.s0_ack : bus.s1_ack) begin
                ack_dt  = c - ena_t;
                g_rdata = (who == 0) ? bus.s0_rdata : bus.s1_rdata;
                g_resp  = (who == 0) ? bus.s0_resp  : bus.s1_resp;
                set_req(who, 1'b0, 4'd0, 32'd0, 32'd0);
            end
        end
        tick();
    endtask

    initial begin
        int          ena_n, ack_dt, n_ack, n_busy;
        int          order [4];
        logic [31:0] g_addr, g_wdata, g_rdata;
        logic [3:0]  g_wstb;
        logic [1:0]  g_resp;
        bit          prev_ena;

        ARESETn = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.m_done = 1'b0; bus.m_rdata = 32'd0; bus.m_bresp = 2'b00; bus.m_rresp = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_ena",   32'(bus.m_ena), 32'd0);
        check("rst_addr",  bus.m_addr,     32'd0);
        check("rst_rdata", bus.s1_rdata,   32'd0);
        ARESETn = 1'b1;
        tick();

        // Single read with a four-cycle master.
        txn(0, 4'd0, 32'h1000, 32'd0, 4, 32'hDEADBEEF, 2'b00, 2'b00,
            ena_n, ack_dt, g_addr, g_wdata, g_wstb, g_rdata, g_resp);
        check("rd_ena_count", 32'(ena_n),  32'd1);
        check("rd_addr",      g_addr,      32'h1000);
        check("rd_latency",   32'(ack_dt), 32'd5);
        check("rd_rdata",     g_rdata,     32'hDEADBEEF);
        check("rd_resp",      32'(g_resp), 32'd0);

        // Write returns BRESP, not RRESP.
        txn(1, 4'hF, 32'h20, 32'h55AA, 2, 32'h0, 2'b11, 2'b00,
            ena_n, ack_dt, g_addr, g_wdata, g_wstb, g_rdata, g_resp);
        check("wr_wstb",  32'(g_wstb), 32'hF);
        check("wr_addr",  g_addr,      32'h20);
        check("wr_wdata", g_wdata,     32'h55AA);
        check("wr_resp",  32'(g_resp), 32'd3);

        // Silent master: SLVERR after TO waiting cycles.
        txn(0, 4'd0, 32'h40, 32'd0, -1, 32'h0, 2'b00, 2'b00,
            ena_n, ack_dt, g_addr, g_wdata, g_wstb, g_rdata, g_resp);
        check("to_latency", 32'(ack_dt), 32'(TO + 1));
        check("to_rdata",   g_rdata,     32'd0);
        check("to_resp",    32'(g_resp), 32'd2);

        // Completion on the timeout cycle wins.
        txn(0, 4'd0, 32'h44, 32'd0, TO, 32'h12345678, 2'b00, 2'b01,
            ena_n, ack_dt, g_addr, g_wdata, g_wstb, g_rdata, g_resp);
        check("tie_latency", 32'(ack_dt), 32'(TO + 1));
        check("tie_rdata",   g_rdata,     32'h12345678);
        check("tie_resp",    32'(g_resp), 32'd1);

        // m_done during the m_ena cycle is ignored, so the access times out.
        txn(1, 4'd0, 32'h48, 32'd0, 0, 32'hCAFEF00D, 2'b00, 2'b01,
            ena_n, ack_dt, g_addr, g_wdata, g_wstb, g_rdata, g_resp);
        check("early_latency", 32'(ack_dt), 32'(TO + 1));
        check("early_resp",    32'(g_resp), 32'd2);

        // Contention from reset: strict alternation, s0 first.
        do_reset(2);
        set_req(0, 1'b1, 4'd0, 32'h100, 32'd0);
        set_req(1, 1'b1, 4'h3, 32'h200, 32'h77);
        n_ack = 0; prev_ena = 1'b0;
        for (int c = 0; c < 60 && n_ack < 4; c++) begin
            tick();
            bus.m_done = prev_ena; bus.m_rdata = 32'(c); bus.m_bresp = 2'b01; bus.m_rresp = 2'b00;
            prev_ena = bus.m_ena;
            if (bus.s0_ack && bus.s1_ack) check("both_ack", 32'd1, 32'd0);
            if (bus.s0_ack) begin order[n_ack] = 0; n_ack++; end
            else if (bus.s1_ack) begin order[n_ack] = 1; n_ack++; end
        end
        bus.m_done = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        check("rr_count", 32'(n_ack), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("rr_grant%0d", k), 32'(order[k]), 32'(k % 2));
        tick(); tick();

        // Reset during WAIT: no ack, late m_done ignored, s0 priority restored.
        set_req(0, 1'b1, 4'd0, 32'h300, 32'd0);
        for (int c = 0; c < 10 && !bus.m_ena; c++) tick();
        tick(); tick();
        ARESETn = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        ARESETn = 1'b1;
        bus.m_done = 1'b1; bus.m_rdata = 32'hBAD0BAD0; bus.m_rresp = 2'b01;
        n_ack = 0; n_busy = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.m_done = 1'b0;
            n_ack  += int'(bus.s0_ack) + int'(bus.s1_ack);
            n_busy += int'(bus.busy);
        end
        check("rst_wait_acks", 32'(n_ack),  32'd0);
        check("rst_wait_busy", 32'(n_busy), 32'd0);
        set_req(0, 1'b1, 4'd0, 32'h310, 32'd0);
        set_req(1, 1'b1, 4'd0, 32'h320, 32'd0);
        g_addr = 32'd0;
        for (int c = 0; c < 10 && !bus.m_ena; c++) tick();
        g_addr = bus.m_addr;
        check("rst_prio_addr", g_addr, 32'h310);
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        do_reset(1);

        // Random traffic, including stray m_done pulses, withdrawals and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            tick();
            ARESETn     = ($urandom_range(0, 499) != 0);
            bus.m_done  = ($urandom_range(0, 4) == 0);
            bus.m_rdata = $urandom;
            bus.m_bresp = 2'($urandom_range(0, 3));
            bus.m_rresp = 2'($urandom_range(0, 3));
            for (int w = 0; w < 2; w++) begin
                logic vld, ack;
                vld = (w == 0) ? bus.s0_valid : bus.s1_valid;
                ack = (w == 0) ? bus.s0_ack   : bus.s1_ack;
                if ((!vld && $urandom_range(0, 2) == 0) || (vld && ack && $urandom_range(0, 1) == 0))
                    set_req(w, 1'b1, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom),
                            $urandom, $urandom);
                else if (vld && (ack || $urandom_range(0, 49) == 0))
                    set_req(w, 1'b0, 4'd0, 32'd0, 32'd0);
            end
        end
        ARESETn = 1'b1;
        bus.m_done = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axilm_arb.md
AXILM_ARB -- requirements
Module: axilm_arb

Interface
REQ-001 Parameter TO_CYCLES, default 255: WAIT-state timeout in ACLK cycles, 1..65535.
REQ-002 ACLK  input  1  sole clock; all logic on rising edge.
REQ-003 ARESETn  input  1  reset, synchronous and active-low.
REQ-004 s0_valid / s1_valid  input  1  requester N has a pending access; held until s N_ack.
REQ-005 s0_wstb / s1_wstb  input  4  byte strobes; non-zero = write, zero = read.
REQ-006 s0_addr / s1_addr  input  32  access address.
REQ-007 s0_wdata / s1_wdata  input  32  write data.
REQ-008 s0_ack / s1_ack  output  1  one-cycle completion pulse to requester N.
REQ-009 s0_rdata / s1_rdata  output  32  read data, valid when s N_ack=1.
REQ-010 s0_resp / s1_resp  output  2  BRESP (write) or RRESP (read), valid when s N_ack=1.
REQ-011 m_ena  output  1  one-cycle start pulse to the AXI-Lite master local bus.
REQ-012 m_wstb / m_addr / m_wdata  output  4/32/32  latched fields of the granted access, stable from m_ena until completion.
REQ-013 m_done  input  1  one-cycle completion pulse from the master.
REQ-014 m_rdata / m_bresp / m_rresp  input  32/2/2  master results, sampled when m_done=1.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; exactly one access in flight.
REQ-017 IDLE: if any s N_valid=1, select winner, latch its wstb/addr/wdata and its index, go to ISSUE next cycle.
REQ-018 Arbitration: round-robin on pointer last_gnt; both valid -> grant the index != last_gnt; one valid -> grant it; last_gnt updated on grant.
REQ-019 ISSUE: m_ena=1 for exactly one cycle; go to WAIT.
REQ-020 WAIT: on m_done=1, latch m_rdata and (wstb!=0 ? m_bresp : m_rresp); go to RESP.
REQ-021 WAIT: 16-bit counter cleared on ISSUE, incremented each WAIT cycle; reaching TO_CYCLES with m_done=0 -> latch rdata=0, resp=2'b10 (SLVERR), go to RESP.
REQ-022 m_done and timeout in same cycle: m_done wins; master results used.
REQ-023 m_done outside WAIT: ignored, no state change.
REQ-024 RESP: s N_ack=1 for the latched index only, for one cycle, with latched rdata/resp; go to IDLE.
REQ-025 Deassertion of s N_valid after grant: ignored; access completes and s N_ack still pulses.
REQ-026 Non-granted requester: s N_ack=0, its s N_rdata/s N_resp hold previous value.
REQ-027 Minimum request-to-ack latency: 3 cycles plus master latency (grant edge, m_ena cycle, m_done cycle, ack cycle); back-to-back grant possible the cycle after RESP.

Reset
REQ-028 ARESETn=0 sampled at a rising edge: state=IDLE, last_gnt=1, counter=0.
REQ-029 During and after reset: m_ena=0, s0_ack=s1_ack=0, busy=0, m_wstb=0, m_addr=0, m_wdata=0, s N_rdata=0, s N_resp=0.
REQ-030 Reset mid-transaction: in-flight access abandoned, no ack issued; subsequent m_done ignored until next ISSUE.

Verification
REQ-031 Single read: s0_valid, wstb=0, addr=0x1000; m_done after 4 cycles with m_rdata=0xDEADBEEF, m_rresp=0 -> one m_ena with addr 0x1000, s0_ack pulse with rdata 0xDEADBEEF, resp 0.
REQ-032 Contention: s0/s1 both valid from reset -> grants s0, s1, s0, s1; each s N_ack exactly once per grant, never both in the same cycle.
REQ-033 Write response: s1 write wstb=0xF, addr=0x20, wdata=0x55AA; m_bresp=2'b11 -> m_wstb=0xF, m_wdata=0x55AA, s1_resp=2'b11.
REQ-034 Timeout: TO_CYCLES=8, m_done never asserted -> s N_ack 8 WAIT cycles after m_ena with resp=2'b10, rdata=0; m_done and timeout coincident -> master results returned.
REQ-035 Reset in WAIT: ARESETn low one cycle, late m_done pulse -> no ack, busy=0, next request arbitrated with s0 priority.
